// File: rtl/mem_lsu.sv
// Memory-stage load/store unit: drives a req/ack data bus,
// aligns store lanes, extends load data and stalls the pipeline.
module mem_lsu #(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] ALUresultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        MisalignM,
  output logic        BusErrM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam logic [7:0] TMAX = 8'(ACK_TIMEOUT - 1);

  state_t      state;
  state_t      nxt;
  logic        acc;
  logic        is_b;
  logic        is_h;
  logic        is_w;
  logic        mis;
  logic        tmo;
  logic [3:0]  strb;
  logic [31:0] wd;
  logic [31:0] ld;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [7:0]  cnt;
  logic [1:0]  lo;
  logic [2:0]  f3;

  assign acc  = MemWriteM | (ResultSrcM == 2'b01);
  assign is_b = (funct3M[1:0] == 2'b00);
  assign is_h = (funct3M[1:0] == 2'b01);
  assign is_w = funct3M[1];
  assign mis  = (is_h & ALUresultM[0]) |
                (is_w & (|ALUresultM[1:0]));
  assign tmo  = (cnt == TMAX);
  assign StallM = acc & (state != DONE);

  always_comb begin
    strb = 4'hF;
    wd   = WriteDataM;
    unique case (1'b1)
      is_b: begin
        strb = 4'b0001 << ALUresultM[1:0];
        wd   = {4{WriteDataM[7:0]}};
      end
      is_h: begin
        strb = 4'b0011 << {ALUresultM[1], 1'b0};
        wd   = {2{WriteDataM[15:0]}};
      end
      default: begin
        strb = 4'hF;
        wd   = WriteDataM;
      end
    endcase
  end

  // Extraction uses the offset/size captured at request time.
  assign ld_b = mem_rdata[{lo, 3'b000} +: 8];
  assign ld_h = mem_rdata[{lo[1], 4'b0000} +: 16];

  always_comb begin
    ld = mem_rdata;
    unique case (1'b1)
      (f3[1:0] == 2'b00):
        ld = f3[2] ? {24'b0, ld_b}
                   : {{24{ld_b[7]}}, ld_b};
      (f3[1:0] == 2'b01):
        ld = f3[2] ? {16'b0, ld_h}
                   : {{16{ld_h[15]}}, ld_h};
      default:
        ld = mem_rdata;
    endcase
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (acc) nxt = mis ? DONE : BUSY;
      BUSY:    if (mem_ack | tmo) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      ReadDataM <= '0;
      MisalignM <= 1'b0;
      BusErrM   <= 1'b0;
      cnt       <= '0;
      lo        <= '0;
      f3        <= '0;
    end else begin
      MisalignM <= 1'b0;
      BusErrM   <= 1'b0;
      case (state)
        IDLE: begin
          if (acc && mis) begin
            MisalignM <= 1'b1;
            ReadDataM <= '0;
          end else if (acc) begin
            mem_req   <= 1'b1;
            mem_we    <= MemWriteM;
            mem_addr  <= {ALUresultM[31:2], 2'b00};
            mem_wdata <= wd;
            mem_wstrb <= MemWriteM ? strb : 4'h0;
            cnt       <= '0;
            lo        <= ALUresultM[1:0];
            f3        <= funct3M;
          end
        end
        BUSY: begin
          if (mem_ack) begin
            mem_req   <= 1'b0;
            ReadDataM <= ld;
          end else if (tmo) begin
            mem_req   <= 1'b0;
            BusErrM   <= 1'b1;
            ReadDataM <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: stores, loads, misalign,
// ack timeout and mid-transaction reset.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        MemWriteM = 1'b0;
  logic [1:0]  ResultSrcM = 2'b00;
  logic [2:0]  funct3M = 3'b000;
  logic [31:0] ALUresultM = '0;
  logic [31:0] WriteDataM = '0;
  logic [31:0] ReadDataM;
  logic        StallM;
  logic        MisalignM;
  logic        BusErrM;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  int checks = 0;
  int errors = 0;

  int          st;
  int          rq;
  logic [31:0] ba;
  logic [31:0] bw;
  logic [3:0]  bs;
  logic        be;
  logic [31:0] rd;
  logic        mi;
  logic        er;

  mem_lsu #(.ACK_TIMEOUT(4)) dut (
    .clk(clk),
    .rst(rst),
    .MemWriteM(MemWriteM),
    .ResultSrcM(ResultSrcM),
    .funct3M(funct3M),
    .ALUresultM(ALUresultM),
    .WriteDataM(WriteDataM),
    .ReadDataM(ReadDataM),
    .StallM(StallM),
    .MisalignM(MisalignM),
    .BusErrM(BusErrM),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata),
    .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one access until the DONE cycle; waits<0 means no ack.
  task automatic run_acc(
    input  logic        we,
    input  logic [1:0]  rs,
    input  logic [2:0]  f,
    input  logic [31:0] a,
    input  logic [31:0] w,
    input  int          waits,
    input  logic [31:0] rdat,
    output int          stalls,
    output int          reqs,
    output logic [31:0] baddr,
    output logic [31:0] bwd,
    output logic [3:0]  bst,
    output logic        bwe,
    output logic [31:0] rdm,
    output logic        mis,
    output logic        berr
  );
    int busy;
    bit seen;
    bit done;
    MemWriteM  = we;
    ResultSrcM = rs;
    funct3M    = f;
    ALUresultM = a;
    WriteDataM = w;
    mem_rdata  = rdat;
    mem_ack    = 1'b0;
    stalls = 0; reqs = 0; busy = 0;
    seen = 0; done = 0;
    baddr = '0; bwd = '0; bst = '0; bwe = 1'b0;
    rdm = '0; mis = 1'b0; berr = 1'b0;
    #1;
    for (int i = 0; i < 40 && !done; i++) begin
      if (StallM === 1'b0) begin
        rdm  = ReadDataM;
        mis  = MisalignM;
        berr = BusErrM;
        mem_ack = 1'b0;
        done = 1;
      end else begin
        stalls++;
        if (mem_req === 1'b1) begin
          reqs++;
          busy++;
          if (!seen) begin
            baddr = mem_addr;
            bwd   = mem_wdata;
            bst   = mem_wstrb;
            bwe   = mem_we;
          end
          seen = 1;
        end
        mem_ack = (mem_req === 1'b1) && (busy == waits + 1);
        @(posedge clk);
        #2;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL run_acc_bound: no DONE within 40 cycles");
    end
    MemWriteM  = 1'b0;
    ResultSrcM = 2'b00;
    mem_ack    = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0) begin
      errors++; $display("FAIL rst_req got %b exp 0", mem_req);
    end
    checks++;
    if (mem_we !== 1'b0) begin
      errors++; $display("FAIL rst_we got %b exp 0", mem_we);
    end
    checks++;
    if (mem_addr !== 32'h0) begin
      errors++; $display("FAIL rst_addr got %h exp 0", mem_addr);
    end
    checks++;
    if (mem_wdata !== 32'h0) begin
      errors++; $display("FAIL rst_wdata got %h exp 0", mem_wdata);
    end
    checks++;
    if (mem_wstrb !== 4'h0) begin
      errors++; $display("FAIL rst_wstrb got %h exp 0", mem_wstrb);
    end
    checks++;
    if (ReadDataM !== 32'h0) begin
      errors++; $display("FAIL rst_rdata got %h exp 0", ReadDataM);
    end
    checks++;
    if (MisalignM !== 1'b0 || BusErrM !== 1'b0) begin
      errors++;
      $display("FAIL rst_pulses got %b%b exp 00", MisalignM, BusErrM);
    end
    checks++;
    if (StallM !== 1'b0) begin
      errors++; $display("FAIL rst_stall got %b exp 0", StallM);
    end
  endtask

  task automatic test_sw();
    run_acc(1'b1, 2'b00, 3'b010, 32'h1000_0008, 32'hDEAD_BEEF,
            0, 32'h0, st, rq, ba, bw, bs, be, rd, mi, er);
    checks++;
    if (ba !== 32'h1000_0008) begin
      errors++; $display("FAIL sw_addr got %h exp 10000008", ba);
    end
    checks++;
    if (bs !== 4'hF) begin
      errors++; $display("FAIL sw_strb got %h exp f", bs);
    end
    checks++;
    if (bw !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL sw_wdata got %h exp deadbeef", bw);
    end
    checks++;
    if (be !== 1'b1) begin
      errors++; $display("FAIL sw_we got %b exp 1", be);
    end
    checks++;
    if (st != 2 || rq != 1) begin
      errors++; $display("FAIL sw_timing stall %0d req %0d exp 2 1", st, rq);
    end
  endtask

  task automatic test_sb();
    run_acc(1'b1, 2'b00, 3'b000, 32'h1000_0003, 32'h0000_00A5,
            1, 32'h0, st, rq, ba, bw, bs, be, rd, mi, er);
    checks++;
    if (bs !== 4'b1000) begin
      errors++; $display("FAIL sb_strb got %b exp 1000", bs);
    end
    checks++;
    if (bw !== 32'hA5A5_A5A5) begin
      errors++; $display("FAIL sb_wdata got %h exp a5a5a5a5", bw);
    end
    checks++;
    if (ba !== 32'h1000_0000 || st != 3) begin
      errors++; $display("FAIL sb_addr got %h stall %0d exp 10000000 3", ba, st);
    end
  endtask

  task automatic test_load_byte();
    run_acc(1'b0, 2'b01, 3'b000, 32'h2000_0002, 32'hFFFF_FFFF,
            3, 32'h1280_3456, st, rq, ba, bw, bs, be, rd, mi, er);
    checks++;
    if (rd !== 32'hFFFF_FF80) begin
      errors++; $display("FAIL lb_data got %h exp ffffff80", rd);
    end
    checks++;
    if (st != 5 || rq != 4) begin
      errors++; $display("FAIL lb_timing stall %0d req %0d exp 5 4", st, rq);
    end
    checks++;
    if (be !== 1'b0 || bs !== 4'h0 || ba !== 32'h2000_0000) begin
      errors++; $display("FAIL lb_bus we %b strb %h addr %h exp 0 0 20000000", be, bs, ba);
    end
    checks++;
    if (ReadDataM !== 32'hFFFF_FF80) begin
      errors++; $display("FAIL lb_hold got %h exp ffffff80", ReadDataM);
    end
    run_acc(1'b0, 2'b01, 3'b100, 32'h2000_0002, 32'h0,
            3, 32'h1280_3456, st, rq, ba, bw, bs, be, rd, mi, er);
    checks++;
    if (rd !== 32'h0000_0080 || st != 5) begin
      errors++; $display("FAIL lbu_data got %h stall %0d exp 00000080 5", rd, st);
    end
  endtask

  task automatic test_misalign();
    run_acc(1'b0, 2'b01, 3'b010, 32'h3000_0006, 32'h0,
            0, 32'h5555_5555, st, rq, ba, bw, bs, be, rd, mi, er);
    checks++;
    if (mi !== 1'b1 || er !== 1'b0) begin
      errors++; $display("FAIL lw_mis_pulse mis %b err %b exp 1 0", mi, er);
    end
    checks++;
    if (rq != 0 || st != 1) begin
      errors++; $display("FAIL lw_mis_timing req %0d stall %0d exp 0 1", rq, st);
    end
    checks++;
    if (rd !== 32'h0) begin
      errors++; $display("FAIL lw_mis_data got %h exp 0", rd);
    end
    checks++;
    if (MisalignM !== 1'b0) begin
      errors++; $display("FAIL mis_pulse_len got %b exp 0", MisalignM);
    end
    run_acc(1'b1, 2'b00, 3'b001, 32'h3000_0001, 32'h1234,
            0, 32'h0, st, rq, ba, bw, bs, be, rd, mi, er);
    checks++;
    if (mi !== 1'b1 || rq != 0) begin
      errors++; $display("FAIL sh_mis mis %b req %0d exp 1 0", mi, rq);
    end
    run_acc(1'b0, 2'b01, 3'b011, 32'h3000_0002, 32'h0,
            0, 32'h0, st, rq, ba, bw, bs, be, rd, mi, er);
    checks++;
    if (mi !== 1'b1 || rq != 0) begin
      errors++; $display("FAIL f3_011_mis mis %b req %0d exp 1 0", mi, rq);
    end
  endtask

  task automatic test_load_half();
    run_acc(1'b0, 2'b01, 3'b001, 32'h2000_0002, 32'h0,
            0, 32'h8001_1234, st, rq, ba, bw, bs, be, rd, mi, er);
    checks++;
    if (rd !== 32'hFFFF_8001) begin
      errors++; $display("FAIL lh_data got %h exp ffff8001", rd);
    end
    run_acc(1'b0, 2'b01, 3'b101, 32'h2000_0000, 32'h0,
            0, 32'h8001_9234, st, rq, ba, bw, bs, be, rd, mi, er);
    checks++;
    if (rd !== 32'h0000_9234) begin
      errors++; $display("FAIL lhu_data got %h exp 00009234", rd);
    end
    run_acc(1'b0, 2'b01, 3'b010, 32'h2000_0004, 32'h0,
            1, 32'hCAFE_F00D, st, rq, ba, bw, bs, be, rd, mi, er);
    checks++;
    if (rd !== 32'hCAFE_F00D || st != 3) begin
      errors++; $display("FAIL lw_data got %h stall %0d exp cafef00d 3", rd, st);
    end
  endtask

  task automatic test_timeout();
    run_acc(1'b0, 2'b01, 3'b001, 32'h4000_0000, 32'h0,
            -1, 32'h1111_1111, st, rq, ba, bw, bs, be, rd, mi, er);
    checks++;
    if (rq != 4) begin
      errors++; $display("FAIL tmo_req_len got %0d exp 4", rq);
    end
    checks++;
    if (er !== 1'b1 || mi !== 1'b0) begin
      errors++; $display("FAIL tmo_pulse err %b mis %b exp 1 0", er, mi);
    end
    checks++;
    if (rd !== 32'h0 || st != 5) begin
      errors++; $display("FAIL tmo_data got %h stall %0d exp 0 5", rd, st);
    end
    checks++;
    if (BusErrM !== 1'b0 || mem_req !== 1'b0 || StallM !== 1'b0) begin
      errors++; $display("FAIL tmo_idle err %b req %b stall %b exp 000", BusErrM, mem_req, StallM);
    end
    run_acc(1'b0, 2'b01, 3'b010, 32'h4000_0008, 32'h0,
            0, 32'h7777_0001, st, rq, ba, bw, bs, be, rd, mi, er);
    checks++;
    if (rd !== 32'h7777_0001 || st != 2) begin
      errors++; $display("FAIL tmo_recover got %h stall %0d exp 77770001 2", rd, st);
    end
  endtask

  task automatic test_rst_mid();
    MemWriteM  = 1'b1;
    ResultSrcM = 2'b00;
    funct3M    = 3'b010;
    ALUresultM = 32'h6000_0004;
    WriteDataM = 32'h1357_9BDF;
    mem_ack    = 1'b0;
    tick();
    checks++;
    if (mem_req !== 1'b1) begin
      errors++; $display("FAIL rstmid_req_on got %b exp 1", mem_req);
    end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    MemWriteM = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    #1;
    checks++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0) begin
      errors++; $display("FAIL rstmid_req got %b we %b exp 0 0", mem_req, mem_we);
    end
    checks++;
    if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_wstrb !== 4'h0) begin
      errors++; $display("FAIL rstmid_bus addr %h wd %h st %h exp 0", mem_addr, mem_wdata, mem_wstrb);
    end
    tick();
    mem_ack = 1'b0;
    checks++;
    if (mem_req !== 1'b0 || ReadDataM !== 32'h0 || BusErrM !== 1'b0) begin
      errors++; $display("FAIL rstmid_ack req %b rd %h err %b exp 0 0 0", mem_req, ReadDataM, BusErrM);
    end
    run_acc(1'b1, 2'b00, 3'b001, 32'h5000_0002, 32'h0000_BEEF,
            0, 32'h0, st, rq, ba, bw, bs, be, rd, mi, er);
    checks++;
    if (bs !== 4'b1100) begin
      errors++; $display("FAIL sh_strb got %b exp 1100", bs);
    end
    checks++;
    if (bw !== 32'hBEEF_BEEF || ba !== 32'h5000_0000) begin
      errors++; $display("FAIL sh_bus wd %h addr %h exp beefbeef 50000000", bw, ba);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_sw();
    test_sb();
    test_load_byte();
    test_misalign();
    test_load_half();
    test_timeout();
    test_rst_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
